// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data memory handshake between the control FSM and memory/IR side.
interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready, input instr);
    modport slave  (input mem_req, input mem_we, output mem_ready, output instr);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with variable-latency
// shared memory, retirement pulse, sticky illegal-instruction and bus-timeout traps.
module multicycle_control_unit #(
    parameter int TIMEOUT   = 16,
    parameter bit EN_ADDUQB = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    multicycle_control_unit_if.master         bus,
    input  logic                              zero_i,
    output logic                              ir_write_o,
    output logic                              pc_write_o,
    output logic [1:0]                        pc_src_o,
    output logic                              reg_write_o,
    output logic [1:0]                        wb_sel_o,
    output logic                              alu_a_sel_o,
    output logic                              alu_src_o,
    output logic [3:0]                        alu_ctrl_o,
    output logic [2:0]                        imm_sel_o,
    output logic                              retire_o,
    output logic                              illegal_o,
    output logic                              bus_err_o,
    output logic [2:0]                        state_o
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_LUI, C_AUIPC, C_JAL, C_JALR
    } cls_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_ADDUQB = 4'd2, ALU_AND = 4'd3, ALU_SLT = 4'd4,
        ALU_PASSB = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8
    } alu_e;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_e        state_q, state_d;
    cls_e          cls_q, cls_d, dec_cls;
    alu_e          op_q, op_d, dec_op;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic          dec_ok, to_hit;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       unused_instr;
    assign opc = bus.instr[6:0];
    assign f3  = bus.instr[14:12];
    assign f7  = bus.instr[31:25];
    assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

    always_comb begin
        dec_ok  = 1'b0;
        dec_cls = C_ALU;
        dec_op  = ALU_ADD;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    dec_ok = 1'b1;
                    case (f3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b001:  dec_op = ALU_SLL;
                        3'b010:  dec_op = ALU_SLT;
                        3'b101:  dec_op = ALU_SRL;
                        3'b111:  dec_op = ALU_AND;
                        default: dec_ok = 1'b0;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    dec_ok = 1'b1;
                    case (f3)
                        3'b000:  dec_op = ALU_SUB;
                        3'b101:  dec_op = ALU_SRA;
                        default: dec_ok = 1'b0;
                    endcase
                end
            end
            7'b0010011: begin dec_cls = C_ADDI;  dec_ok = (f3 == 3'b000); end
            7'b0000011: begin dec_cls = C_LW;    dec_ok = (f3 == 3'b010); end
            7'b0100011: begin dec_cls = C_SW;    dec_ok = (f3 == 3'b010); end
            7'b1100011: begin dec_cls = C_BEQ;   dec_ok = (f3 == 3'b000); end
            7'b0110111: begin dec_cls = C_LUI;   dec_ok = 1'b1; end
            7'b0010111: begin dec_cls = C_AUIPC; dec_ok = 1'b1; end
            7'b1101111: begin dec_cls = C_JAL;   dec_ok = 1'b1; end
            7'b1100111: begin dec_cls = C_JALR;  dec_ok = (f3 == 3'b000); end
            7'b0001011: begin dec_op = ALU_ADDUQB; dec_ok = EN_ADDUQB; end
            default: ;
        endcase
    end

    assign to_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        op_d        = op_q;
        cnt_d       = '0;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 2'b00;
        reg_write_o = 1'b0;
        wb_sel_o    = 2'b00;
        alu_a_sel_o = 1'b0;
        alu_src_o   = 1'b0;
        alu_ctrl_o  = ALU_ADD;
        imm_sel_o   = 3'b000;
        retire_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                op_d  = dec_op;
                if (dec_ok) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (cls_q)
                    C_ALU:  alu_ctrl_o = op_q;
                    C_ADDI, C_LW, C_JALR: alu_src_o = 1'b1;
                    C_SW:   begin alu_src_o = 1'b1; imm_sel_o = 3'b001; end
                    C_BEQ:  begin alu_ctrl_o = ALU_SUB; imm_sel_o = 3'b010; end
                    C_LUI:  begin alu_ctrl_o = ALU_PASSB; alu_src_o = 1'b1; imm_sel_o = 3'b011; end
                    C_AUIPC: begin alu_a_sel_o = 1'b1; alu_src_o = 1'b1; imm_sel_o = 3'b011; end
                    C_JAL:  begin alu_a_sel_o = 1'b1; alu_src_o = 1'b1; imm_sel_o = 3'b100; end
                    default: ;
                endcase
                if (cls_q == C_BEQ) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = zero_i ? 2'b01 : 2'b00;
                    retire_o   = 1'b1;
                    state_d    = S_FETCH;
                end else if (cls_q == C_LW || cls_q == C_SW) begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (cls_q == C_SW);
                if (bus.mem_ready) begin
                    if (cls_q == C_SW) begin
                        pc_write_o = 1'b1;
                        retire_o   = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
                if (cls_q == C_LW) wb_sel_o = 2'b01;
                if (cls_q == C_JAL || cls_q == C_JALR) wb_sel_o = 2'b10;
                if (cls_q == C_JAL)  pc_src_o = 2'b01;
                if (cls_q == C_JALR) pc_src_o = 2'b10;
            end
            S_TRAP: ;
            default: state_d = S_FETCH;
        endcase
        // Stalled request: count the wait, trap once the budget is spent.
        if (bus.mem_req && !bus.mem_ready) begin
            if (to_hit) begin
                state_d   = S_TRAP;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ALU;
            op_q      <= ALU_ADD;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;
    assign state_o   = state_q;
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RV32I-subset core: sequences every instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with a shared instruction/data memory of variable latency, and drives the datapath strobes. It generalises the single-cycle control decoder to a shared-memory, stalled datapath. It adds instruction retirement, illegal-instruction and bus-timeout traps, and a parameter-gated ADDUQB custom extension. It sits between the instruction register and the datapath muxes, ALU and register file.

## Interface
- TIMEOUT, 16, max cycles a memory request may wait for mem_ready; 0 disables the timeout
- EN_ADDUQB, 1, 1 = opcode 0001011 (ADDUQB) legal; 0 = treated as illegal
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register contents; the datapath latches it on ir_write; stable from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (read or write)
- mem_we  out  1  write request; valid only with mem_req
- ir_write  out  1  latch the fetched word into the IR
- pc_write  out  1  update the PC
- pc_src  out  2  00 pc+4, 01 pc+imm (branch/JAL), 10 ALU result with bit0 cleared (JALR)
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 memory data, 10 pc+4
- alu_a_sel  out  1  0 rs1, 1 PC (AUIPC)
- alu_src  out  1  0 rs2, 1 immediate
- alu_ctrl  out  4  0000 add, 0001 sub, 0010 adduqb, 0011 and, 0100 slt, 0101 pass-B (LUI), 0110 sll, 0111 srl, 1000 sra
- imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky: illegal instruction trap
- bus_err  out  1  sticky: memory timeout trap
- state  out  3  FSM state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: assert mem_req with mem_we=0. On mem_ready, assert ir_write and go to DECODE. Otherwise hold.
- DECODE: one cycle. Classify instr[6:0], funct3 and funct7.
  - Legal set: ADD, SUB, SLL, SLT, SRL, SRA, AND (0110011); ADDI (0010011, funct3 000); LW (0000011, funct3 010); SW (0100011, funct3 010); BEQ (1100011, funct3 000); LUI; AUIPC; JAL; JALR (funct3 000); ADDUQB (0001011, only if EN_ADDUQB).
  - Any other encoding goes to TRAP with illegal=1.
- EXEC: drive alu_ctrl, alu_src, alu_a_sel and imm_sel for the instruction. ADDI always uses add with a sign-extended immediate; no sign-dependent ALU op.
  - BEQ: pc_write=1, pc_src = zero ? 01 : 00, retire=1, then FETCH.
  - LW and SW: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1, mem_we=1 for SW and 0 for LW. Hold until mem_ready.
  - On mem_ready, LW goes to WB.
  - On mem_ready, SW asserts pc_write (pc_src 00) and retire, then FETCH.
- WB: assert reg_write and pc_write, retire=1, then FETCH.
  - wb_sel: 01 for LW, 10 for JAL/JALR, 00 otherwise.
  - pc_src: 01 for JAL, 10 for JALR, 00 otherwise.
  - reg_write stays asserted for rd=x0; the register file ignores x0.
- Strobe exclusivity: each instruction asserts pc_write exactly once and retire exactly once, in the same cycle.
- Timeout: a counter runs while mem_req=1 and mem_ready=0, and clears on mem_ready or on leaving the state. If it reaches TIMEOUT (TIMEOUT>0), go to TRAP with bus_err=1.
- TRAP: all strobes 0. Held until reset.

## Timing
- Outputs are Moore: a function of state, the registered class decode and the counter, never of mem_ready, with these exceptions: ir_write, and pc_write/retire in MEM, are qualified by mem_ready in the same cycle.
- Reset values: state=FETCH; illegal=0; bus_err=0; counter=0.
  - Every strobe is 0 except mem_req, which is 1 in the first cycle after reset because the FSM is in FETCH.
  - Selects reset to 0.
- Reset mid-instruction (any state, including TRAP): next cycle is FETCH with no pc_write and no reg_write.
- Latency with zero-wait memory (mem_ready already high at the request):
  - BEQ: 3 cycles.
  - SW: 4 cycles.
  - R-type, ADDI, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- Timeout boundary: with TIMEOUT=N, a request still unanswered after N cycles traps on cycle N+1. mem_ready arriving on cycle N is accepted normally.

## Test plan
- Reset then ADD (0x00208033), mem_ready tied 1 -> states 0,1,2,4,0; reg_write, pc_write and retire high only in WB; alu_ctrl=0000.
- BEQ with zero=1, then zero=0 -> pc_write in EXEC with pc_src 01, then 00; reg_write never asserted; 3 cycles each.
- LW with mem_ready delayed 2 cycles in both FETCH and MEM -> 9 cycles total; wb_sel=01 in WB; mem_we=0 throughout.
- SW, then JAL -> SW: mem_we=1 in MEM and retire on the mem_ready cycle. JAL: WB with wb_sel=10, pc_src=01.
- Opcode 0001011 with EN_ADDUQB=0, and 0x00000000 -> TRAP, illegal=1, all strobes 0; reset returns to FETCH with illegal=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err=1 and state=7 on cycle 5. Repeat with mem_ready on cycle 4 -> no trap.
